// File: rtl/data_memory_arbiter.sv
// rtl/data_memory_arbiter.sv - shares the single-port data memory between core EX stage and debug port
// Core has priority; debug wins on halt or after STARVE_LIMIT consecutive losing cycles.
module data_memory_arbiter #(
  parameter int ADDR_WIDTH   = 10,
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  core_req,
  input  logic                  core_we,
  input  logic [ADDR_WIDTH-1:0] core_addr,
  input  logic [XLEN-1:0]       core_wdata,
  output logic [XLEN-1:0]       core_rdata,
  output logic                  core_stall,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  input  logic [XLEN-1:0]       dbg_wdata,
  input  logic                  dbg_halt,
  output logic                  dbg_ready,
  output logic                  dbg_rvalid,
  output logic [XLEN-1:0]       dbg_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [XLEN-1:0]       mem_wdata,
  output logic                  mem_wren,
  input  logic [XLEN-1:0]       mem_q
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt;
  logic       dbg_rd_q;
  logic       grant_dbg;
  logic       grant_core;

  // Grants are qualified by reset so every request-derived output is low while reset is held.
  always_comb begin
    grant_dbg  = reset && dbg_req && (!core_req || dbg_halt || (starve_cnt == LIMIT));
    grant_core = reset && core_req && !grant_dbg;
  end

  always_comb begin
    core_stall = reset && core_req && grant_dbg;
    dbg_ready  = grant_dbg;
    mem_addr   = core_addr;
    mem_wdata  = core_wdata;
    mem_wren   = grant_core && core_we;
    if (grant_dbg) begin
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
      mem_wren  = dbg_we;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      starve_cnt <= 4'd0;
      dbg_rd_q   <= 1'b0;
    end else begin
      dbg_rd_q <= grant_dbg && !dbg_we;
      if (!dbg_req || grant_dbg)
        starve_cnt <= 4'd0;
      else if (starve_cnt != LIMIT)
        starve_cnt <= starve_cnt + 4'd1;
    end
  end

  always_comb begin
    core_rdata = mem_q;
    dbg_rvalid = dbg_rd_q;
    dbg_rdata  = dbg_rd_q ? mem_q : '0;
  end

endmodule
